// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver and transmitter.
package uart_pkg;

    // Frame geometry and sampling constants.
    localparam int DATA_BITS = 8;
    localparam int OSR       = 16;
    localparam int MID_START = 7;

    // Line-side state machine states, common to both directions.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_state_e;

    // Clock cycles per oversample tick, truncated toward zero.
    function automatic int uart_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OSR);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks, with a
// restart input that realigns the phase to an external event.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Free-running divider; a restart forces the count back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 16x oversampling, mid-bit sampling, valid/ack
// output handshake with framing-error pulse and sticky overrun flag.
module uart_receiver #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int OSR      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_data,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ack,
    output logic       frame_err,
    output logic       overrun,
    input  logic       overrun_clr,
    output logic       busy
);

    import uart_pkg::*;

    localparam int DIV = uart_div(CLK_FREQ, BAUD);

    localparam logic [3:0] MID_CNT  = 4'(MID_START);
    localparam logic [3:0] LAST_CNT = 4'(OSR - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    // Reject unsupported configurations at elaboration time.
    generate
        if (OSR != uart_pkg::OSR) begin : g_bad_osr
            $error("uart_receiver: OSR must be 16");
        end
        if (DIV < 1) begin : g_bad_div
            $error("uart_receiver: CLK_FREQ too low for BAUD*16");
        end
    endgenerate

    logic                 sync_meta;
    logic                 rx_s;
    uart_state_e          state_reg;
    logic [3:0]           scnt;
    logic [2:0]           bcnt;
    logic [DATA_BITS-1:0] shift;
    logic                 tick;
    logic                 restart;
    logic                 mid_stop;
    logic                 load;
    logic                 stop_bad;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            sync_meta <= rx_data;
            rx_s      <= sync_meta;
        end
    end

    // Align the tick phase to the detected start edge.
    assign restart = (state_reg == IDLE) && !rx_s;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    assign mid_stop = (state_reg == STOP) && tick && (scnt == LAST_CNT);
    assign load     = mid_stop && rx_s;
    assign stop_bad = mid_stop && !rx_s;
    assign busy     = (state_reg != IDLE);

    // Frame state machine: start validation, data shifting, stop check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            scnt      <= '0;
            bcnt      <= '0;
            shift     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!rx_s) begin
                        state_reg <= START;
                        scnt      <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (scnt == MID_CNT) begin
                            if (rx_s) begin
                                // Line went back high before mid start bit: glitch.
                                state_reg <= IDLE;
                            end else begin
                                state_reg <= DATA;
                                scnt      <= '0;
                                bcnt      <= '0;
                            end
                        end else begin
                            scnt <= scnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (scnt == LAST_CNT) begin
                            scnt  <= '0;
                            // Shift in at the MSB so the first bit lands at bit 0.
                            shift <= {rx_s, shift[DATA_BITS-1:1]};
                            if (bcnt == LAST_BIT) begin
                                state_reg <= STOP;
                            end else begin
                                bcnt <= bcnt + 3'd1;
                            end
                        end else begin
                            scnt <= scnt + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (scnt == LAST_CNT) begin
                            scnt <= '0;
                            // Good stop returns straight to IDLE so a start bit
                            // immediately following is still caught.
                            state_reg <= rx_s ? IDLE : WAIT_IDLE;
                        end else begin
                            scnt <= scnt + 4'd1;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Output register, handshake and error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= stop_bad;

            // A new byte takes priority over an acknowledge in the same cycle.
            if (load) begin
                data_out   <= shift;
                data_valid <= 1'b1;
            end else if (data_ack) begin
                data_valid <= 1'b0;
            end

            // Setting overrun wins over clearing it.
            if (load && data_valid && !data_ack) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus a
// randomized frame stream compared against a behavioural model.
module tb_uart_receiver;

    localparam int BIT_CLK = 160;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_data = 1'b1;
    logic       data_ack = 1'b0;
    logic       overrun_clr = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;
    int fe_count = 0;
    int lat = 0;

    // Behavioural model of the receiver's visible state.
    logic [7:0] exp_data = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_ovr = 1'b0;
    int         exp_fe = 0;

    uart_receiver #(
        .CLK_FREQ (16_000_000),
        .BAUD     (100_000),
        .OSR      (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ack    (data_ack),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Count every cycle frame_err is seen high; one pulse per bad frame.
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_line(input logic v, input int n);
        rx_data = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int bc);
        drive_line(1'b0, bc);
        for (int i = 0; i < 8; i++) drive_line(b[i], bc);
        drive_line(stop, bc);
    endtask

    task automatic pulse_ack(input string tag);
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        check({tag, "_ack_clears"}, data_valid, 1'b0);
    endtask

    task automatic wait_valid(input string tag, input logic [7:0] exp, output int n);
        n = 0;
        while (data_valid !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, data_valid, 1'b1);
        check({tag, "_data"}, data_out, exp);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        int gap;
        logic [7:0] b;
        logic stop_ok;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_data", data_out, 8'h00);
        check("rst_valid", data_valid, 1'b0);
        check("rst_fe", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        drive_line(1'b1, 20);
        check("rst_idle_busy", busy, 1'b0);

        // Single byte with latency measurement from the start edge.
        fork
            send_frame(8'hA5, 1'b1, BIT_CLK);
            wait_valid("a5", 8'hA5, lat);
        join
        $display("a5: latency %0d clk", lat);
        check("a5_latency_window", (lat >= 1515 && lat <= 1530), 1'b1);
        pulse_ack("a5");

        // Back-to-back frames with no idle between them.
        fork
            begin
                send_frame(8'h00, 1'b1, BIT_CLK);
                send_frame(8'hFF, 1'b1, BIT_CLK);
            end
            begin
                wait_valid("b2b0", 8'h00, lat);
                pulse_ack("b2b0");
                wait_valid("b2b1", 8'hFF, lat);
                pulse_ack("b2b1");
            end
        join
        drive_line(1'b1, 20);
        check("b2b_fe", fe_count, exp_fe);
        check("b2b_ovr", overrun, 1'b0);

        // Short glitch must not start a frame.
        drive_line(1'b0, 40);
        drive_line(1'b1, 200);
        check("glitch_valid", data_valid, 1'b0);
        check("glitch_busy", busy, 1'b0);
        send_frame(8'h3C, 1'b1, BIT_CLK);
        drive_line(1'b1, 10);
        check("after_glitch_valid", data_valid, 1'b1);
        check("after_glitch_data", data_out, 8'h3C);
        pulse_ack("after_glitch");

        // Framing error followed by a held-low line, then a good frame.
        send_frame(8'h55, 1'b0, BIT_CLK);
        drive_line(1'b0, 500);
        exp_fe++;
        check("ferr_count", fe_count, exp_fe);
        check("ferr_valid", data_valid, 1'b0);
        check("ferr_busy_wait", busy, 1'b1);
        drive_line(1'b1, 20);
        check("ferr_busy_idle", busy, 1'b0);
        send_frame(8'h81, 1'b1, BIT_CLK);
        drive_line(1'b1, 10);
        check("after_ferr_valid", data_valid, 1'b1);
        check("after_ferr_data", data_out, 8'h81);
        pulse_ack("after_ferr");

        // Overrun: second byte lands while the first is unacknowledged.
        send_frame(8'h11, 1'b1, BIT_CLK);
        drive_line(1'b1, 20);
        check("ovr_first_data", data_out, 8'h11);
        check("ovr_first_flag", overrun, 1'b0);
        send_frame(8'h22, 1'b1, BIT_CLK);
        drive_line(1'b1, 20);
        check("ovr_set", overrun, 1'b1);
        check("ovr_data", data_out, 8'h22);
        check("ovr_valid", data_valid, 1'b1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("ovr_clr", overrun, 1'b0);
        pulse_ack("ovr");

        exp_data  = 8'h22;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;

        // Randomized frames with baud skew, bad stops, and random handshake.
        for (int k = 0; k < 20; k++) begin
            b       = 8'($urandom);
            stop_ok = ($urandom_range(0, 4) != 0);
            bc      = int'($urandom_range(155, 165));
            gap     = int'($urandom_range(5, 200));
            send_frame(b, stop_ok, bc);
            if (!stop_ok) begin
                drive_line(1'b0, int'($urandom_range(50, 300)));
                exp_fe++;
            end else begin
                if (exp_valid) exp_ovr = 1'b1;
                exp_valid = 1'b1;
                exp_data  = b;
            end
            drive_line(1'b1, gap);
            $display("rnd%0d: byte 0x%02h stop %0d bit %0d clk -> data 0x%02h valid %0d ovr %0d",
                     k, b, stop_ok, bc, data_out, data_valid, overrun);
            check($sformatf("rnd%0d_data", k), data_out, exp_data);
            check($sformatf("rnd%0d_valid", k), data_valid, exp_valid);
            check($sformatf("rnd%0d_ovr", k), overrun, exp_ovr);
            check($sformatf("rnd%0d_fe", k), fe_count, exp_fe);
            check($sformatf("rnd%0d_busy", k), busy, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                data_ack = 1'b1;
                @(negedge clk);
                data_ack = 1'b0;
                exp_valid = 1'b0;
            end
            if ($urandom_range(0, 2) == 0) begin
                overrun_clr = 1'b1;
                @(negedge clk);
                overrun_clr = 1'b0;
                exp_ovr = 1'b0;
            end
        end

        // Reset asserted mid-frame clears everything immediately.
        send_frame(8'h5A, 1'b1, BIT_CLK);
        drive_line(1'b1, 10);
        check("mid_rst_pre_valid", data_valid, 1'b1);
        drive_line(1'b0, 300);
        check("mid_rst_pre_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", data_out, 8'h00);
        check("mid_rst_valid", data_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ovr", overrun, 1'b0);
        check("mid_rst_fe", frame_err, 1'b0);
        rx_data = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        drive_line(1'b1, 400);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_valid", data_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
